spi_flash_loader: RTL and testbench
===================================

# spi_flash_loader

Sequencer that streams a block of bytes out of an SPI serial flash by driving the 68k-style register port of the `spi` peripheral as a bus master. Sits directly upstream of `spi`: takes a start address and byte count, issues the flash READ command sequence, and delivers the received data as big-endian 16-bit words on a valid/ready stream. The boot logic uses it to copy the ROM image into RAM before releasing the CPU from reset.

## Interface
Parameters:
- `REG_ADDR`, 8'h00: `spi` register address driven on `spi_addr`.
- `CTRL_SEL`, 8'h12: control byte written via `lds` to select flash chip select / clock setting.
- `CTRL_DESEL`, 8'h00: control byte written via `lds` to deselect.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `start_addr` in 24: flash byte address.
- `length` in 16: byte count, 0..65535.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `word_data` out 16: output word, first byte in [15:8].
- `word_valid` out 1: word available.
- `word_ready` in 1: consumer accepts word when high with `word_valid`.
- `spi_data_write` out 16: to `spi.data_write`.
- `spi_data_read` in 16: from `spi.data_read`; rx byte in [7:0].
- `spi_addr` out 8: to `spi.addr`, constant `REG_ADDR`.
- `spi_uds`, `spi_lds`, `spi_rw` out 1 each: to `spi` strobes.
- `spi_ack` in 1: from `spi.ack`.
- `spi_active` in 1: from `spi.spi_active`.

## Operation
- States: IDLE, SEL, TX, WAIT_ACT, WAIT_IDLE, RD, OUT, DESEL, FIN.
- IDLE + `start`: latch `start_addr`, `length`; if `length`=0 go FIN directly (no SPI access), else SEL. `start` outside IDLE ignored.
- SEL: one-cycle write, `spi_lds`=1, `spi_rw`=0, `spi_data_write`={8'h00, CTRL_SEL}.
- TX: one-cycle write, `spi_uds`=1, `spi_rw`=0, `spi_data_write`={tx_byte, 8'h00}. Byte sequence: 8'h03, addr[23:16], addr[15:8], addr[7:0], then 8'hFF per data byte.
- WAIT_ACT: wait for `spi_active`=1; WAIT_IDLE: wait for `spi_active`=0.
- Header bytes: after WAIT_IDLE return to TX for next byte, rx discarded. Data bytes: go RD.
- RD: hold `spi_rw`=1, `spi_lds`=1 until `spi_ack`=1; capture `spi_data_read[7:0]` that cycle, drop strobes next cycle.
- Even byte index → word[15:8]; odd → word[7:0], then OUT. Last byte on even index (odd `length`): word[7:0]=8'h00, go OUT.
- OUT: `word_valid`=1, hold `word_data` stable until `word_ready`; next TX not issued before acceptance (backpressure stalls SPI clock).
- After last word accepted: DESEL (one-cycle `lds` write {8'h00, CTRL_DESEL}) → FIN.
- FIN: `done`=1 one cycle, `busy`=0 next cycle, return IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `word_valid`=0, `word_data`=0, `spi_data_write`=0, `spi_uds`=`spi_lds`=`spi_rw`=0, state IDLE.
- Write strobes are exactly one clock wide; never two strobes in one cycle.
- `busy` rises the cycle after `start` is sampled.
- `length`=0: `done` two cycles after `start`, no strobes.
- Reset mid-transfer: immediate return to reset values; chip select state is the responsibility of `spi`'s own reset.
- WAIT_ACT/WAIT_IDLE have no timeout; stuck `spi` is recovered by reset only.
- Byte counter 16-bit, address counter not incremented (flash auto-increments).

## Configuration
- `SPI_FLASH_FAST_READ_EN` defined: command 8'h0B, one extra 8'hFF dummy byte after address (5 header bytes), rx discarded.
- Undefined: command 8'h03, 4 header bytes.

## Test plan
- Reset with bench `spi` + flash model: all outputs at reset values, no strobes for 20 cycles.
- `start_addr`=24'h000100, `length`=4, flash bytes 11 22 33 44, `word_ready`=1 → tx 03 00 01 00 FF FF FF FF, words 16'h1122, 16'h3344, one `done`, final `lds` write 8'h00.
- `length`=3, bytes AA BB CC → words 16'hAABB, 16'hCC00.
- `length`=0 → `done` 2 cycles after `start`, zero `uds`/`lds` strobes.
- `length`=4, `word_ready` low 50 cycles on first word → `word_data` stable 16'h1122, no `uds` strobe until accepted.
- `SPI_FLASH_FAST_READ_EN` build, `length`=2 → tx 0B, addr×3, FF, FF, FF; single word correct; reset asserted mid data byte → outputs return to reset values same cycle.

Source files
------------

// File: rtl/spi_flash_loader.sv
// Streams a block of bytes out of an SPI flash via the spi register port and emits big-endian 16-bit words.
// Define SPI_FLASH_FAST_READ_EN to use FAST READ (8'h0B) with one dummy byte after the address.
module spi_flash_loader #(
  parameter logic [7:0] REG_ADDR   = 8'h00,
  parameter logic [7:0] CTRL_SEL   = 8'h12,
  parameter logic [7:0] CTRL_DESEL = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] spi_data_write,
  input  logic [15:0] spi_data_read,
  output logic [7:0]  spi_addr,
  output logic        spi_uds,
  output logic        spi_lds,
  output logic        spi_rw,
  input  logic        spi_ack,
  input  logic        spi_active
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]  READ_CMD  = 8'h0B;
  localparam int unsigned HDR_BYTES = 5;
`else
  localparam logic [7:0]  READ_CMD  = 8'h03;
  localparam int unsigned HDR_BYTES = 4;
`endif
  localparam int unsigned HDR_W = 3;

  typedef enum logic [3:0] {
    IDLE, SEL, TX, WAIT_ACT, WAIT_IDLE, RD, OUT, DESEL, FIN
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        addr_q, addr_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        byte_idx_q, byte_idx_d;
  logic [HDR_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic               data_phase_q, data_phase_d;
  logic [7:0]         tx_byte;
  logic [7:0]         rx_byte;
  logic               busy_d, done_d, word_valid_d, uds_d, lds_d, rw_d;
  logic [15:0]        word_data_d, data_write_d;
  logic               unused_rx_hi;

  assign spi_addr     = REG_ADDR;
  assign rx_byte      = spi_data_read[7:0];
  assign unused_rx_hi = ^spi_data_read[15:8];

  // Header bytes come from hdr_idx; once the header is sent, every TX is a dummy clock-out byte.
  always_comb begin
    case (hdr_idx_q)
      3'd0:    tx_byte = READ_CMD;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    hdr_idx_d    = hdr_idx_q;
    data_phase_d = data_phase_q;
    word_data_d  = word_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = start_addr;
          len_d        = length;
          byte_idx_d   = 16'd0;
          hdr_idx_d    = '0;
          data_phase_d = 1'b0;
          state_d      = (length == 16'd0) ? FIN : SEL;
        end
      end
      SEL: state_d = TX;
      TX: begin
        data_phase_d = (hdr_idx_q == HDR_W'(HDR_BYTES));
        if (hdr_idx_q != HDR_W'(HDR_BYTES)) hdr_idx_d = hdr_idx_q + 3'd1;
        state_d = WAIT_ACT;
      end
      WAIT_ACT:  if (spi_active) state_d = WAIT_IDLE;
      WAIT_IDLE: if (!spi_active) state_d = data_phase_q ? RD : TX;
      RD: begin
        if (spi_ack) begin
          byte_idx_d = byte_idx_q + 16'd1;
          if (!byte_idx_q[0]) begin
            if (byte_idx_q == len_q - 16'd1) begin
              word_data_d = {rx_byte, 8'h00};
              state_d     = OUT;
            end else begin
              word_data_d = {rx_byte, word_data[7:0]};
              state_d     = TX;
            end
          end else begin
            word_data_d = {word_data[15:8], rx_byte};
            state_d     = OUT;
          end
        end
      end
      // Next TX waits for acceptance so a stalled consumer also stalls the SPI clock.
      OUT:   if (word_ready) state_d = (byte_idx_q == len_q) ? DESEL : TX;
      DESEL: state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so strobes line up with the state they belong to.
    busy_d       = (state_d != IDLE) || (state_q == FIN);
    done_d       = (state_q == FIN);
    word_valid_d = (state_d == OUT);
    uds_d        = (state_d == TX);
    lds_d        = (state_d == SEL) || (state_d == RD) || (state_d == DESEL);
    rw_d         = (state_d == RD);
    case (state_d)
      SEL:     data_write_d = {8'h00, CTRL_SEL};
      TX:      data_write_d = {tx_byte, 8'h00};
      DESEL:   data_write_d = {8'h00, CTRL_DESEL};
      default: data_write_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= 24'd0;
      len_q          <= 16'd0;
      byte_idx_q     <= 16'd0;
      hdr_idx_q      <= '0;
      data_phase_q   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      word_data      <= 16'h0000;
      word_valid     <= 1'b0;
      spi_data_write <= 16'h0000;
      spi_uds        <= 1'b0;
      spi_lds        <= 1'b0;
      spi_rw         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      byte_idx_q     <= byte_idx_d;
      hdr_idx_q      <= hdr_idx_d;
      data_phase_q   <= data_phase_d;
      busy           <= busy_d;
      done           <= done_d;
      word_data      <= word_data_d;
      word_valid     <= word_valid_d;
      spi_data_write <= data_write_d;
      spi_uds        <= uds_d;
      spi_lds        <= lds_d;
      spi_rw         <= rw_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Bench for spi_flash_loader: behavioural spi/flash model plus queue scoreboard for tx bytes and words.
module tb_spi_flash_loader;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam int HDR = 5;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int HDR = 4;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = 24'd0;
  logic [15:0] length = 16'd0;
  logic        busy, done, word_valid, spi_uds, spi_lds, spi_rw;
  logic        word_ready = 1'b1;
  logic [15:0] word_data, spi_data_write;
  logic [15:0] spi_data_read;
  logic [7:0]  spi_addr;
  logic        spi_ack, spi_active;

  int checks = 0, passes = 0, fails = 0;
  int strobe_cnt = 0, uds_cnt = 0, lds_wr_cnt = 0, done_cnt = 0;
  int unexp = 0, overlap = 0;
  logic [15:0] last_lds = 16'hFFFF;
  logic        prev_uds = 1'b0;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_words[$];

  logic [7:0]  mem [0:255];
  int          pos, shift_cnt;
  logic [23:0] faddr;

  always #5 clk = ~clk;

  spi_flash_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .spi_data_write(spi_data_write), .spi_data_read(spi_data_read), .spi_addr(spi_addr),
    .spi_uds(spi_uds), .spi_lds(spi_lds), .spi_rw(spi_rw), .spi_ack(spi_ack), .spi_active(spi_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [23:0] t;
    t = a;
    return mem[t[7:0]];
  endfunction

  // spi + flash model: a uds write shifts one byte; a lds read is acked one cycle later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_active    <= 1'b0;
      spi_ack       <= 1'b0;
      spi_data_read <= 16'h0000;
      shift_cnt     <= 0;
      pos           <= 0;
      faddr         <= 24'd0;
    end else begin
      spi_ack    <= spi_lds && spi_rw && !spi_ack;
      spi_active <= (shift_cnt >= 1) && (shift_cnt <= 8);
      if (spi_lds && !spi_rw && spi_data_write[7:0] == 8'h12) pos <= 0;
      if (spi_uds && !spi_rw) begin
        case (pos)
          1: faddr[23:16] <= spi_data_write[15:8];
          2: faddr[15:8]  <= spi_data_write[15:8];
          3: faddr[7:0]   <= spi_data_write[15:8];
          default: ;
        endcase
        if (pos >= HDR) spi_data_read <= {8'h00, flash_byte(faddr + 24'(pos - HDR))};
        else spi_data_read <= 16'h00EE;
        pos       <= pos + 1;
        shift_cnt <= 10;
      end else if (shift_cnt > 0) begin
        shift_cnt <= shift_cnt - 1;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if ((spi_uds && spi_lds) || (spi_uds && prev_uds)) overlap++;
      prev_uds = spi_uds;
      if (spi_uds || spi_lds) strobe_cnt++;
      if (spi_lds && !spi_rw) begin
        lds_wr_cnt++;
        last_lds = spi_data_write;
      end
      if (spi_uds && !spi_rw) begin
        uds_cnt++;
        if (exp_tx.size() == 0) unexp++;
        else check("tx_byte", 32'(spi_data_write[15:8]), 32'(exp_tx.pop_front()));
      end
      if (word_valid && word_ready) begin
        if (exp_words.size() == 0) unexp++;
        else check("word", 32'(word_data), 32'(exp_words.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_tx(input logic [23:0] a, input int len);
    exp_tx.push_back(CMD);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    if (HDR == 5) exp_tx.push_back(8'hFF);
    for (int i = 0; i < len; i++) exp_tx.push_back(8'hFF);
  endtask

  task automatic start_xfer(input logic [23:0] a, input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = len;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad, u0, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values and quiet idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 32'({busy, done, word_valid, spi_uds, spi_lds, spi_rw}), 32'd0);
    check("rst_word", 32'(word_data), 32'd0);
    check("rst_wdata", 32'(spi_data_write), 32'd0);
    check("spi_addr", 32'(spi_addr), 32'd0);
    reset_n = 1'b1;
    strobe_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_strobes", 32'(strobe_cnt), 32'd0);

    // Even length, 4 bytes
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    push_tx(24'h000100, 4);
    exp_words.push_back(16'h1122); exp_words.push_back(16'h3344);
    lds_wr_cnt = 0;
    start_xfer(24'h000100, 16'd4);
    wait_done("done_len4");
    check("tx_left_len4", 32'(exp_tx.size()), 32'd0);
    check("words_left_len4", 32'(exp_words.size()), 32'd0);
    check("desel_data", 32'(last_lds), 32'h0000);
    check("lds_writes", 32'(lds_wr_cnt), 32'd2);

    // Odd length pads the final low byte
    mem[8'h40] = 8'hAA; mem[8'h41] = 8'hBB; mem[8'h42] = 8'hCC;
    push_tx(24'h000040, 3);
    exp_words.push_back(16'hAABB); exp_words.push_back(16'hCC00);
    start_xfer(24'h000040, 16'd3);
    wait_done("done_len3");
    check("words_left_len3", 32'(exp_words.size()), 32'd0);

    // Zero length: done two cycles after start, no SPI access
    strobe_cnt = 0;
    u0 = done_cnt;
    start_xfer(24'h123456, 16'd0);
    check("len0_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("len0_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("len0_idle", 32'({busy, done}), 32'd0);
    check("len0_strobes", 32'(strobe_cnt), 32'd0);
    check("len0_pulses", 32'(done_cnt - u0), 32'd1);

    // Backpressure on the first word
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    push_tx(24'h000100, 4);
    exp_words.push_back(16'h1122); exp_words.push_back(16'h3344);
    word_ready = 1'b0;
    start_xfer(24'h000100, 16'd4);
    n = 0;
    while (!word_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(word_valid), 32'd1);
    u0 = uds_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (word_data !== 16'h1122 || !word_valid) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_no_uds", 32'(uds_cnt - u0), 32'd0);
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_done("done_bp");
    check("words_left_bp", 32'(exp_words.size()), 32'd0);

    // Two bytes make a single word
    mem[8'h80] = 8'h5A; mem[8'h81] = 8'hC3;
    push_tx(24'h010280, 2);
    exp_words.push_back(16'h5AC3);
    start_xfer(24'h010280, 16'd2);
    wait_done("done_len2");
    check("tx_left_len2", 32'(exp_tx.size()), 32'd0);
    check("words_left_len2", 32'(exp_words.size()), 32'd0);

    // Asynchronous reset in the middle of a data byte read
    push_tx(24'h010280, 2);
    exp_words.push_back(16'h5AC3);
    start_xfer(24'h010280, 16'd2);
    n = 0;
    while (!spi_rw && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_rd_reached", 32'(spi_rw), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctl", 32'({busy, done, word_valid, spi_uds, spi_lds, spi_rw}), 32'd0);
    check("mid_rst_data", 32'({word_data, spi_data_write}), 32'd0);
    exp_tx.delete();
    exp_words.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    strobe_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_quiet", 32'({busy, strobe_cnt[7:0]}), 32'd0);

    check("strobe_rules", 32'(overlap), 32'd0);
    check("unexpected_outputs", 32'(unexp), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
